ps2_receiver: RTL and testbench
===============================

Name: ps2_receiver

Overview:
- PS/2 device-side receiver for the keyboard FPGA. Deserialises host-to-device frames from the PS/2 bus into bytes.
- Checks frame integrity: start bit, odd parity and stop bit.
- Flags the host Reset command (0xFF) on reset_required so the keyboard control logic can run its reset/BAT response.
- Sits between the PS/2 pins and the command/response logic.

Parameters:
- RESET_CMD, 8'hFF, command byte that raises reset_required.
- FRAME_BITS, 11, bits per frame (start + 8 data + parity + stop); fixed, not meant to be overridden.

Ports:
- ps2_clk  input  1  PS/2 bus clock; the block's only clock; all state updates on its falling edge.
- rst_n  input  1  asynchronous active-low reset.
- ps2_data  input  1  PS/2 data line, sampled on ps2_clk falling edge.
- reset_done  input  1  sampled on the ps2_clk falling edge; clears reset_required.
- data  output  8  last correctly received byte.
- data_valid  output  1  one-ps2_clk-cycle pulse when a good frame completes.
- frame_error  output  1  one-cycle pulse when a frame is rejected.
- reset_required  output  1  sticky flag: a good frame equal to RESET_CMD was received.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; bit counter=0; shift register=0; data=8'h00; data_valid=0; frame_error=0; reset_required=0. Asserting reset mid-frame discards that frame.
- All sequential logic is on negedge ps2_clk with async clear on negedge rst_n.
- Bit order: start(0), D0..D7 (LSB first), parity (odd over D0..D7 plus parity bit), stop(1).
- IDLE: sampled ps2_data=1 -> stay IDLE. Sampled 0 -> start bit accepted, go to DATA with count=0.
- DATA: shift sample into bit[count]; after the 8th bit go to PARITY.
- PARITY: store the sample and go to STOP.
- STOP: evaluate the frame on this edge, then return to IDLE.
  - Good frame: stop=1 and XOR(D7..D0, parity)=1. Then data <= byte and data_valid=1 for that cycle.
  - Good frame with byte == RESET_CMD: also reset_required <= 1, in the same cycle as data_valid.
  - Bad parity or stop=0: frame_error=1 for one cycle; data and reset_required unchanged.
- Latency: outputs update on the falling edge that samples the stop bit (11th edge of the frame).
- data_valid and frame_error deassert on the next falling edge. They never assert together.
- reset_required clearing:
  - Held until rst_n=0 or reset_done=1 is sampled.
  - reset_done and a new RESET_CMD completion on the same edge: set wins, flag stays 1.
  - reset_done while the flag is already 0: no effect.
- Back-to-back frames: the next start bit may arrive on the edge immediately after stop; no idle gap is required. Arbitrary gaps with ps2_clk high are allowed.
- No timeout exists, since there is no system clock. A desynchronised stream recovers through the stop-bit check plus the IDLE rule that ignores 1s.
- Non-command bytes (e.g. 0xED, 0xF4) only produce data/data_valid.

Decomposition:
- Shared package ps2_pkg:
  - state enum (IDLE, DATA, PARITY, STOP);
  - PS2_FRAME_BITS=11;
  - command constants CMD_RESET=8'hFF, CMD_RESEND=8'hFE, CMD_SET_LEDS=8'hED.
- Optional sub-module ps2_parity (8-bit odd-parity check); otherwise a single module.

Test Plan:
- Frame 0_11111111_1_1 (0xFF, parity 1) after reset -> on the 11th falling edge: data=8'hFF, data_valid pulse, reset_required=1, and it stays 1 through subsequent frames.
- Frame 0xED (bits 0_10110111_1_1, LSB first, parity 1) -> data=8'hED, data_valid pulse, reset_required unchanged (0 from reset).
- 0xFF with parity bit 0 -> frame_error pulse, no data_valid, data unchanged, reset_required stays 0.
- Valid 0x00 frame with stop bit 0 -> frame_error pulse. A following good 0xF4 frame (parity 0) is received correctly: data=8'hF4.
- rst_n pulsed low after 5 bits of a 0xFF frame -> all outputs 0 immediately. A complete new 0xFF frame then sets reset_required=1.
- reset_required=1, then reset_done=1 on one falling edge -> flag 0. reset_done on the same edge as a 0xFF stop bit -> flag 1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame geometry, host command bytes and FSM states.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_RESEND   = 8'hFE;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_parity.sv
// Odd-parity check over a data byte plus its transmitted parity bit.
module ps2_parity (
  input  logic [7:0] data_i,
  input  logic       parity_i,
  output logic       odd_ok_o
);

  assign odd_ok_o = ^{data_i, parity_i};

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-side receiver: deserialises host frames on falling ps2_clk, checks
// start/parity/stop, and latches a sticky flag when the host Reset command arrives.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter logic [7:0] RESET_CMD  = CMD_RESET,
  parameter int         FRAME_BITS = PS2_FRAME_BITS
) (
  input  logic       ps2_clk,
  input  logic       rst_n,
  input  logic       ps2_data,
  input  logic       reset_done,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_error,
  output logic       reset_required
);

  // Start, parity and stop bits frame the payload.
  localparam int         DATA_BITS = FRAME_BITS - 3;
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  ps2_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       par_q, par_d;
  logic [7:0] data_q, data_d;
  logic       dv_q, dv_d;
  logic       fe_q, fe_d;
  logic       rr_q, rr_d;
  logic       parity_ok;
  logic       frame_ok;

  ps2_parity u_parity (
    .data_i   (shreg_q),
    .parity_i (par_q),
    .odd_ok_o (parity_ok)
  );

  // Evaluated while the stop bit is on the line.
  assign frame_ok = ps2_data & parity_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!ps2_data) begin
          state_d = ST_DATA;
          cnt_d   = 3'd0;
        end
      end
      ST_DATA: begin
        shreg_d[cnt_q] = ps2_data;
        if (cnt_q == LAST_BIT) state_d = ST_PARITY;
        else                   cnt_d   = cnt_q + 3'd1;
      end
      ST_PARITY: begin
        par_d   = ps2_data;
        state_d = ST_STOP;
      end
      ST_STOP: begin
        state_d = ST_IDLE;
        if (frame_ok) begin
          data_d = shreg_q;
          dv_d   = 1'b1;
        end else begin
          fe_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A fresh Reset command outranks a simultaneous reset_done.
  always_comb begin
    rr_d = rr_q;
    if (dv_d && (shreg_q == RESET_CMD)) rr_d = 1'b1;
    else if (reset_done)                rr_d = 1'b0;
  end

  always_ff @(negedge ps2_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      shreg_q <= 8'h00;
      par_q   <= 1'b0;
      data_q  <= 8'h00;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      rr_q    <= rr_d;
    end
  end

  assign data           = data_q;
  assign data_valid     = dv_q;
  assign frame_error    = fe_q;
  assign reset_required = rr_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench for ps2_receiver: frames are driven on rising ps2_clk, expected
// outcomes are queued at drive time and matched against each output pulse.
module tb_ps2_receiver;

  logic       ps2_clk;
  logic       rst_n;
  logic       ps2_data;
  logic       reset_done;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;
  logic       reset_required;

  typedef struct {
    logic [7:0] d;
    logic       dv;
    logic       fe;
    logic       rr;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_rr   = 1'b0;

  ps2_receiver dut (
    .ps2_clk        (ps2_clk),
    .rst_n          (rst_n),
    .ps2_data       (ps2_data),
    .reset_done     (reset_done),
    .data           (data),
    .data_valid     (data_valid),
    .frame_error    (frame_error),
    .reset_required (reset_required)
  );

  initial ps2_clk = 1'b1;
  always #10 ps2_clk = ~ps2_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame; the stop bit is sampled on the falling edge after return.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input logic rdone);
    logic [10:0] bits;
    logic        good;
    exp_t        e;
    bits = {stp, par, b, 1'b0};
    good = stp & (^{b, par});
    if (good) begin
      m_data = b;
      if (b == 8'hFF) m_rr = 1'b1;
      else if (rdone) m_rr = 1'b0;
    end else if (rdone) begin
      m_rr = 1'b0;
    end
    e.d = m_data; e.dv = good; e.fe = ~good; e.rr = m_rr;
    sb.push_back(e);
    for (int i = 0; i < 11; i++) begin
      @(posedge ps2_clk);
      ps2_data   = bits[i];
      reset_done = (i == 10) ? rdone : 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ps2_clk);
      ps2_data   = 1'b1;
      reset_done = 1'b0;
    end
  endtask

  // Every output pulse must match the oldest outstanding expectation.
  always @(negedge ps2_clk) begin
    #1;
    if (data_valid || frame_error) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {data_valid, frame_error}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data", data, e.d);
        chk("data_valid", data_valid, e.dv);
        chk("frame_error", frame_error, e.fe);
        chk("reset_required", reset_required, e.rr);
      end
    end
  end

  initial begin
    logic [7:0] rb;
    logic       rp;
    logic       rs;
    int         mode;
    logic [10:0] abort_bits;

    rst_n      = 1'b0;
    ps2_data   = 1'b1;
    reset_done = 1'b0;
    #5;
    chk("rst_data", data, 8'h00);
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_fe", frame_error, 1'b0);
    chk("rst_rr", reset_required, 1'b0);
    @(posedge ps2_clk);
    rst_n = 1'b1;
    idle(2);

    send_frame(8'hED, 1'b1, 1'b1, 1'b0);
    idle(2);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    idle(1);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hF4, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("rr_sticky", reset_required, 1'b1);

    @(posedge ps2_clk);
    reset_done = 1'b1;
    @(posedge ps2_clk);
    reset_done = 1'b0;
    m_rr = 1'b0;
    @(negedge ps2_clk);
    #1;
    chk("rr_cleared", reset_required, 1'b0);
    idle(1);

    send_frame(8'hFF, 1'b1, 1'b1, 1'b1);
    idle(2);
    chk("rr_set_wins", reset_required, 1'b1);

    abort_bits = {1'b1, 1'b1, 8'hFF, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(posedge ps2_clk);
      ps2_data = abort_bits[i];
    end
    @(posedge ps2_clk);
    #5;
    rst_n    = 1'b0;
    ps2_data = 1'b1;
    #1;
    chk("abort_data", data, 8'h00);
    chk("abort_dv", data_valid, 1'b0);
    chk("abort_fe", frame_error, 1'b0);
    chk("abort_rr", reset_required, 1'b0);
    m_data = 8'h00;
    m_rr   = 1'b0;
    #2;
    rst_n = 1'b1;
    idle(2);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    idle(2);

    for (int k = 0; k < 24; k++) begin
      rb   = 8'($urandom);
      mode = $urandom_range(0, 3);
      rp   = ~^rb;
      rs   = 1'b1;
      if (mode == 0) rp = ^rb;
      if (mode == 1) rs = 1'b0;
      send_frame(rb, rp, rs, 1'($urandom_range(0, 1)));
      if (rs && ($urandom_range(0, 1) == 1)) idle($urandom_range(1, 3));
    end
    idle(4);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
